// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller for the EX-stage ALU operands.
// Tracks destination info of the instructions in EX and MEM and registers mux selects alongside ID/EX.
module fwd_hazard_ctrl #(
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           id_valid,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic [RAW-1:0] id_rd,
  input  logic           id_reg_write,
  input  logic           id_mem_read,
  input  logic           flush,
  output logic [1:0]     fwd_a_sel,
  output logic [1:0]     fwd_b_sel,
  output logic           stall
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // Shadow slot for the instruction currently in EX.
  logic           ex_valid_q, ex_valid_d;
  logic [RAW-1:0] ex_rd_q, ex_rd_d;
  logic           ex_reg_write_q, ex_reg_write_d;
  logic           ex_mem_read_q, ex_mem_read_d;

  // MEM slot; the load flag is no longer needed once a producer has left EX.
  // The WB slot is not kept: the register file writes before it reads, so WB never forwards.
  logic           mem_valid_q;
  logic [RAW-1:0] mem_rd_q;
  logic           mem_reg_write_q;

  logic           ex_producer;
  logic           mem_producer;
  logic           bubble;
  logic [RAW-1:0] src [2];
  logic [1:0]     sel_d [2];
  logic [1:0]     sel_q [2];
  logic           load_hit [2];

  assign src[0] = id_rs;
  assign src[1] = id_rt;

  assign ex_producer  = ex_valid_q && ex_reg_write_q && (ex_rd_q != '0);
  assign mem_producer = mem_valid_q && mem_reg_write_q && (mem_rd_q != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign load_hit[gi] = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
                            (ex_rd_q == src[gi]);

      // Nearer producer wins; stalls and other bubbles carry the register-file code.
      always_comb begin
        sel_d[gi] = SEL_RF;
        if (!bubble) begin
          if (ex_producer && (ex_rd_q == src[gi])) begin
            sel_d[gi] = SEL_MEM;
          end else if (mem_producer && (mem_rd_q == src[gi])) begin
            sel_d[gi] = SEL_WB;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sel_q[gi] <= SEL_RF;
        end else begin
          sel_q[gi] <= sel_d[gi];
        end
      end
    end
  endgenerate

  assign stall  = id_valid && (load_hit[0] || load_hit[1]);
  assign bubble = stall || flush || !id_valid;

  always_comb begin
    ex_valid_d     = 1'b0;
    ex_rd_d        = '0;
    ex_reg_write_d = 1'b0;
    ex_mem_read_d  = 1'b0;
    if (!bubble) begin
      ex_valid_d     = 1'b1;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write;
      ex_mem_read_d  = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q      <= 1'b0;
      ex_rd_q         <= '0;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= '0;
      mem_reg_write_q <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rd_q         <= ex_rd_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      mem_valid_q     <= ex_valid_q;
      mem_rd_q        <= ex_rd_q;
      mem_reg_write_q <= ex_reg_write_q;
    end
  end

  assign fwd_a_sel = sel_q[0];
  assign fwd_b_sel = sel_q[1];

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: the driver queues expected stall and select values,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_fwd_hazard_ctrl;
  localparam int RAW = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           id_valid = 1'b0;
  logic [RAW-1:0] id_rs = '0;
  logic [RAW-1:0] id_rt = '0;
  logic [RAW-1:0] id_rd = '0;
  logic           id_reg_write = 1'b0;
  logic           id_mem_read = 1'b0;
  logic           flush = 1'b0;
  logic [1:0]     fwd_a_sel;
  logic [1:0]     fwd_b_sel;
  logic           stall;

  fwd_hazard_ctrl #(.RAW(RAW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] a;
    logic [1:0] b;
    int         step;
  } sel_exp_t;

  typedef struct {
    int   cyc;
    logic s;
    int   step;
  } stall_exp_t;

  sel_exp_t   sel_q[$];
  stall_exp_t stall_q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int step_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    while (stall_q.size() > 0 && stall_q[0].cyc <= cyc) begin
      stall_exp_t e;
      e = stall_q.pop_front();
      tests++;
      if (e.cyc != cyc || stall !== e.s) begin
        fails++;
        $display("FAIL stall step %0d: got %b required %b (due cyc %0d, now %0d)",
                 e.step, stall, e.s, e.cyc, cyc);
      end else begin
        $display("[TB] step %0d stall=%b ok", e.step, stall);
      end
    end
    while (sel_q.size() > 0 && sel_q[0].cyc <= cyc) begin
      sel_exp_t e;
      e = sel_q.pop_front();
      tests++;
      if (e.cyc != cyc || fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
        fails++;
        $display("FAIL sel step %0d: got a=%b b=%b required a=%b b=%b",
                 e.step, fwd_a_sel, fwd_b_sel, e.a, e.b);
      end else begin
        $display("[TB] step %0d sel a=%b b=%b ok", e.step, fwd_a_sel, fwd_b_sel);
      end
    end
  end

  // One ID-stage cycle: apply inputs, queue the stall due now and the selects due after the edge.
  task automatic step(input logic r, input logic v, input int rs, input int rt, input int rd,
                      input logic rw, input logic mr, input logic fl,
                      input logic chk_stall, input logic exp_stall,
                      input logic [1:0] ea, input logic [1:0] eb);
    stall_exp_t se;
    sel_exp_t   xe;
    @(posedge clk);
    #1;
    step_no++;
    rst          = r;
    id_valid     = v;
    id_rs        = RAW'(rs);
    id_rt        = RAW'(rt);
    id_rd        = RAW'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    if (chk_stall) begin
      se.cyc = cyc; se.s = exp_stall; se.step = step_no;
      stall_q.push_back(se);
    end
    xe.cyc = cyc + 1; xe.a = ea; xe.b = eb; xe.step = step_no;
    sel_q.push_back(xe);
  endtask

  initial begin
    //   rst v  rs  rt  rd  rw  mr  fl  cs  st  a      b
    step(1, 0,  0,  0,  0,  0,  0,  0,  0,  0, 2'b00, 2'b00);
    step(1, 0,  0,  0,  0,  0,  0,  0,  1,  0, 2'b00, 2'b00);
    // EX-to-EX
    step(0, 1,  1,  2,  3,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  3,  4, 10,  1,  0,  0,  1,  0, 2'b10, 2'b00);
    // MEM-to-EX
    step(0, 1,  0,  0,  5,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  1,  1,  7,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  2,  5, 11,  1,  0,  0,  1,  0, 2'b00, 2'b01);
    // Priority
    step(0, 1,  0,  0,  6,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  1,  1,  6,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  6,  6, 12,  1,  0,  0,  1,  0, 2'b10, 2'b10);
    // Load-use
    step(0, 1,  0,  0,  8,  1,  1,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  8,  0, 13,  1,  0,  0,  1,  1, 2'b00, 2'b00);
    step(0, 1,  8,  0, 13,  1,  0,  0,  1,  0, 2'b01, 2'b00);
    // Register zero and non-writers
    step(0, 1,  1,  1,  0,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  0,  0, 14,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  0,  0,  9,  0,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  9,  9, 15,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  9,  9, 16,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    // Invalid ID yields a bubble; the producer then forwards from MEM
    step(0, 1,  0,  0, 17,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 0, 17, 17,  0,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1, 17,  0, 19,  1,  0,  0,  1,  0, 2'b01, 2'b00);
    // Flush
    step(0, 1,  0,  0,  4,  1,  0,  1,  1,  0, 2'b00, 2'b00);
    step(0, 1,  4,  4, 18,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1,  0,  0, 20,  1,  1,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1, 20, 20, 21,  1,  0,  1,  1,  1, 2'b00, 2'b00);
    step(0, 0,  0,  0,  0,  0,  0,  0,  1,  0, 2'b00, 2'b00);
    // Reset with a load in EX and its consumer in ID
    step(0, 1,  0,  0,  4,  1,  1,  0,  1,  0, 2'b00, 2'b00);
    step(1, 1,  4,  4, 22,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    step(0, 1,  4,  4, 22,  1,  0,  0,  1,  0, 2'b00, 2'b00);
    step(0, 1, 22,  4, 23,  1,  0,  0,  1,  0, 2'b10, 2'b00);
    step(0, 0,  0,  0,  0,  0,  0,  0,  1,  0, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sel_q.size() != 0 || stall_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d select and %0d stall expectations left, required 0",
               sel_q.size(), stall_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Generates the 2-bit select codes that drive the 3:1 forwarding muxes on the EX-stage ALU operands (operand A and operand B).
- Generates the load-use stall.
- Keeps its own shadow pipeline of destination-register info (EX, MEM, WB slots), fed from the decode stage.
- Sits alongside the ID/EX pipeline register: decode inputs in, registered select codes out, aligned with the instruction entering EX.

Parameters:
- RAW, 5, register-address width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  RAW  source register 1 of the ID instruction.
- id_rt  input  RAW  source register 2 of the ID instruction.
- id_rd  input  RAW  destination register of the ID instruction.
- id_reg_write  input  1  ID instruction writes the register file.
- id_mem_read  input  1  ID instruction is a load.
- flush  input  1  branch taken; the ID instruction must not enter EX.
- fwd_a_sel  output  2  operand-A mux select for the instruction in EX.
- fwd_b_sel  output  2  operand-B mux select for the instruction in EX.
- stall  output  1  hold PC and IF/ID this cycle; bubble into EX.

Behaviour:
- Select encoding (fixed, matches the mux):
  - 00 = register-file value.
  - 01 = WB-stage result.
  - 10 = MEM-stage result.
  - 11 is never driven.
- Shadow slots: ex, mem, wb. Each slot holds {valid, rd, reg_write, mem_read}.
- Each rising edge, unless rst:
  - wb <= mem.
  - mem <= ex.
  - ex <= ID info, or a bubble.
- The bubble (valid=0, reg_write=0, mem_read=0) enters ex when any of these is true: stall=1, flush=1, id_valid=0.
- stall is combinational and is 1 when all of the following hold:
  - ex.valid and ex.mem_read are set.
  - ex.rd != 0.
  - id_valid is set.
  - ex.rd matches id_rs, or ex.rd matches id_rt.
- flush wins over stall for the ex bubble; the stall output itself still follows its equation.
- Forward selects are computed from the ID sources against the current ex and mem slots (these become mem and wb next cycle). They are registered into fwd_a_sel / fwd_b_sel on the same edge the instruction enters EX.
- Select rule for each source src (id_rs for A, id_rt for B):
  - 10 if ex.valid, ex.reg_write, ex.rd != 0 and ex.rd == src.
  - else 01 if mem.valid, mem.reg_write, mem.rd != 0 and mem.rd == src.
  - else 00.
- Priority: the nearer producer (10) wins when both slots match.
- Register 0 is never forwarded.
- If the ex entry is a load matching src, stall is asserted; the registered selects for that cycle are 00 (bubble).
- Selects for a bubble entering EX are 00.
- After a load-use stall, the load sits in mem. The re-presented consumer then gets 01 (value from the load's WB stage).
- No forwarding beyond WB: the register file writes before it reads in the same cycle.
- Reset:
  - All slots invalid.
  - fwd_a_sel = fwd_b_sel = 00.
  - stall = 0 (all slots invalid, so the equation yields 0).
- Reset mid-operation discards all in-flight producers. The first post-reset instruction sees 00/00.
- The same-cycle rs == rt case gives identical A and B selects.
- Latency: one cycle from the ID inputs to the selects; zero cycles to stall.

Test Plan:
1. EX-to-EX forwarding.
   - Stimulus: rst for 2 cycles, then ID add rd=3 (reg_write), next cycle ID sub rs=3 rt=4.
   - Required: when sub is in EX, fwd_a_sel=10, fwd_b_sel=00, stall never 1.
2. MEM-to-EX forwarding.
   - Stimulus: add rd=5, an unrelated instruction (rd=7), then an instruction with rs=2 rt=5.
   - Required: fwd_a_sel=00, fwd_b_sel=01.
3. Priority.
   - Stimulus: add rd=6, add rd=6, then an instruction with rs=6 rt=6.
   - Required: both selects=10.
4. Load-use.
   - Stimulus: lw rd=8, then an instruction with rs=8 held valid.
   - Required:
     - stall=1 for exactly one cycle, with 00/00 registered for the bubble.
     - The next cycle has stall=0 and the consumer enters EX with fwd_a_sel=01.
5. Register zero and non-writers.
   - Stimulus: add rd=0, then rs=0; separately, a store (reg_write=0) to rd=9, then rs=9.
   - Required: all selects 00, stall 0.
6. Flush and reset.
   - Stimulus: add rd=4 asserted with flush=1, then rs=4.
   - Required: select 00.
   - Then: lw rd=4 in ex with rst=1 pulsed while a consumer with rs=4 is in ID.
   - Required: next cycle stall=0 and selects 00/00.
